// File: rtl/instr_encoder.sv
// Field-level RV32I instruction encoder: validates a request, packs the word and writes it to imem.
// Defining ENC_ERR_COUNT_EN adds err_count, a saturating count of rejected requests.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [31:0]       mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
`ifdef ENC_ERR_COUNT_EN
  output logic [7:0]        err_count,
`endif
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers on a cycle with in_valid && in_ready; a write transfers
  // on a cycle with mem_wr_en && mem_wr_ready, and addr/data stay frozen until it does.

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_EMIT, S_ERR} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;

  state_t            state_q;
  logic [3:0]        op_q;
  logic [2:0]        f3_q;
  logic [6:0]        f7_q;
  logic [4:0]        rd_q, rs1_q, rs2_q;
  logic [31:0]       imm_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              wr_en_q, err_valid_q;
  logic [1:0]        err_code_q;
`ifdef ENC_ERR_COUNT_EN
  logic [7:0]        err_count_q;
`endif

  logic        op_bad, f_bad, i_bad, chk_err;
  logic [1:0]  chk_code;
  logic [31:0] word_d;
  logic        i_ok, b_ok, j_ok, u_ok, sh_ok;

  // Range checks reduce to "all bits above the field equal the sign bit".
  assign i_ok  = (&imm_q[31:11]) | ~(|imm_q[31:11]);
  assign b_ok  = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
  assign j_ok  = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];
  assign u_ok  = ~(|imm_q[11:0]);
  assign sh_ok = ~(|imm_q[31:5]);

  always_comb begin
    op_bad = 1'b0;
    f_bad  = 1'b0;
    i_bad  = 1'b0;
    word_d = '0;
    case (op_q)
      4'd0: begin
        i_bad  = ~u_ok;
        word_d = {imm_q[31:12], rd_q, OPC_LUI};
      end
      4'd1: begin
        i_bad  = ~u_ok;
        word_d = {imm_q[31:12], rd_q, OPC_AUIPC};
      end
      4'd2: begin
        i_bad  = ~j_ok;
        word_d = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OPC_JAL};
      end
      4'd3: begin
        f_bad  = (f3_q != 3'b000);
        i_bad  = ~i_ok;
        word_d = {imm_q[11:0], rs1_q, 3'b000, rd_q, OPC_JALR};
      end
      4'd4: begin
        f_bad  = (f3_q == 3'b010) || (f3_q == 3'b011);
        i_bad  = ~b_ok;
        word_d = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OPC_BRANCH};
      end
      4'd5: begin
        f_bad  = !(f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        i_bad  = ~i_ok;
        word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_LOAD};
      end
      4'd6: begin
        f_bad  = !(f3_q inside {3'b000, 3'b001, 3'b010});
        i_bad  = ~i_ok;
        word_d = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OPC_STORE};
      end
      4'd7: begin
        f_bad  = !((f7_q == 7'h00) ||
                   ((f7_q == 7'h20) && ((f3_q == 3'b000) || (f3_q == 3'b101))));
        word_d = {f7_q, rs2_q, rs1_q, f3_q, rd_q, OPC_REG};
      end
      4'd8: begin
        if ((f3_q == 3'b001) || (f3_q == 3'b101)) begin
          // Shifts carry funct7 in imm[11:5] and a 5-bit shamt in imm[4:0].
          f_bad  = (f3_q == 3'b001) ? (f7_q != 7'h00)
                                    : !((f7_q == 7'h00) || (f7_q == 7'h20));
          i_bad  = ~sh_ok;
          word_d = {f7_q, imm_q[4:0], rs1_q, f3_q, rd_q, OPC_IMM};
        end else begin
          i_bad  = ~i_ok;
          word_d = {imm_q[11:0], rs1_q, f3_q, rd_q, OPC_IMM};
        end
      end
      default: op_bad = 1'b1;
    endcase
  end

  assign chk_err  = op_bad | f_bad | i_bad;
  assign chk_code = op_bad ? 2'b00 : (f_bad ? 2'b01 : 2'b10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      f3_q        <= '0;
      f7_q        <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      addr_q      <= BASE_ADDR;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
`ifdef ENC_ERR_COUNT_EN
      err_count_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (restart) begin
            addr_q      <= BASE_ADDR;
`ifdef ENC_ERR_COUNT_EN
            err_count_q <= '0;
`endif
          end
          if (in_valid) begin
            op_q    <= in_op;
            f3_q    <= in_func3;
            f7_q    <= in_func7;
            rd_q    <= in_rd;
            rs1_q   <= in_rs1;
            rs2_q   <= in_rs2;
            imm_q   <= in_imm;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_err) begin
            err_valid_q <= 1'b1;
            err_code_q  <= chk_code;
`ifdef ENC_ERR_COUNT_EN
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
`endif
            state_q     <= S_ERR;
          end else begin
            wr_en_q <= 1'b1;
            data_q  <= word_d;
            state_q <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (mem_wr_ready) begin
            wr_en_q <= 1'b0;
            addr_q  <= addr_q + ADDR_W'(3'd4);
            state_q <= S_IDLE;
          end
        end
        S_ERR: begin
          err_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign mem_wr_en   = wr_en_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign dbg_state   = state_q;
`ifdef ENC_ERR_COUNT_EN
  assign err_count   = err_count_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program fragments plus random requests against a field-rule model.
module tb_instr_encoder;

  logic        clk, rst_n, restart, in_valid, in_ready;
  logic [3:0]  in_op;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        mem_wr_en, mem_wr_ready, err_valid;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [1:0]  err_code, dbg_state;
`ifdef ENC_ERR_COUNT_EN
  logic [7:0]  err_count;
`endif

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_func3(in_func3), .in_func7(in_func7), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .err_valid(err_valid), .err_code(err_code),
`ifdef ENC_ERR_COUNT_EN
    .err_count(err_count),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_encode(input logic [31:0] op, input logic [31:0] f3,
                                     input logic [31:0] f7, input logic [31:0] rd,
                                     input logic [31:0] rs1, input logic [31:0] rs2,
                                     input logic [31:0] u, output bit e,
                                     output logic [1:0] code, output logic [31:0] w);
    int s;
    bit fb, ib;
    s  = int'($signed(u));
    fb = 1'b0;
    ib = 1'b0;
    w  = 32'd0;
    e  = 1'b0;
    code = 2'b00;
    case (op)
      0, 1: begin
        ib = (u % 4096) != 0;
        w  = (u - (u % 4096)) | (rd << 7) | ((op == 0) ? 32'h37 : 32'h17);
      end
      2: begin
        ib = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21) |
             (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12) | (rd << 7) | 32'h6f;
      end
      3: begin
        fb = f3 != 0;
        ib = (s < -2048) || (s > 2047);
        w  = ((u & 32'hfff) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      end
      4: begin
        fb = (f3 == 2) || (f3 == 3);
        ib = (s < -4096) || (s > 4094) || (s % 2 != 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (rs2 << 20) |
             (rs1 << 15) | (f3 << 12) | (((u >> 1) & 32'hf) << 8) |
             (((u >> 11) & 1) << 7) | 32'h63;
      end
      5: begin
        fb = !(f3 inside {0, 1, 2, 4, 5});
        ib = (s < -2048) || (s > 2047);
        w  = ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      end
      6: begin
        fb = f3 > 2;
        ib = (s < -2048) || (s > 2047);
        w  = (((u >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
             ((u & 32'h1f) << 7) | 32'h23;
      end
      7: begin
        fb = !((f7 == 0) || ((f7 == 32'h20) && ((f3 == 0) || (f3 == 5))));
        w  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      end
      8: begin
        if ((f3 == 1) || (f3 == 5)) begin
          fb = (f3 == 1) ? (f7 != 0) : !((f7 == 0) || (f7 == 32'h20));
          ib = (s < 0) || (s > 31);
          w  = (f7 << 25) | ((u & 32'h1f) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end else begin
          ib = (s < -2048) || (s > 2047);
          w  = ((u & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        end
      end
      default: begin
        e    = 1'b1;
        code = 2'b00;
        return;
      end
    endcase
    e    = fb | ib;
    code = fb ? 2'b01 : 2'b10;
  endfunction

  // ---------------- scoreboard / compare ----------------
  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [31:0] word;
    int          due;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] m_addr = 32'd0;
  int          m_cnt = 0;
  logic [31:0] last_wr_addr = 32'hFFFF_FFFF;
  logic [31:0] last_wr_data = 32'hDEAD_BEEF;
  logic [1:0]  last_err_code = 2'b11;
  int          wr_seen = 0;
  int          err_seen = 0;

  initial begin
    forever begin
      bit          was_idle, e;
      logic [1:0]  c;
      logic [31:0] w;
      ev_t         ev;
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_addr = 32'd0;
        m_cnt  = 0;
        continue;
      end
      was_idle = (exp_q.size() == 0);
      check("in_ready", in_ready, was_idle);
      if (!was_idle && cyc >= exp_q[0].due) begin
        if (exp_q[0].is_err) begin
          check("err_valid", err_valid, 1'b1);
          check("err_code", err_code, exp_q[0].code);
          check("no_wr_on_err", mem_wr_en, 1'b0);
          last_err_code = err_code;
          err_seen++;
          if (m_cnt < 255) m_cnt++;
          void'(exp_q.pop_front());
        end else begin
          check("wr_en", mem_wr_en, 1'b1);
          check("wr_addr", mem_wr_addr, m_addr);
          check("wr_data", mem_wr_data, exp_q[0].word);
          check("no_err_on_wr", err_valid, 1'b0);
          if (mem_wr_ready) begin
            last_wr_addr = mem_wr_addr;
            last_wr_data = mem_wr_data;
            wr_seen++;
            m_addr = m_addr + 32'd4;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("wr_en_quiet", mem_wr_en, 1'b0);
        check("err_quiet", err_valid, 1'b0);
      end
`ifdef ENC_ERR_COUNT_EN
      check("err_count", err_count, m_cnt);
`endif
      if (was_idle && restart) begin
        m_addr = 32'd0;
        m_cnt  = 0;
      end
      if (was_idle && in_valid) begin
        ref_encode(in_op, in_func3, in_func7, in_rd, in_rs1, in_rs2, in_imm, e, c, w);
        ev.is_err = e;
        ev.code   = c;
        ev.word   = w;
        ev.due    = cyc + 2;
        exp_q.push_back(ev);
      end
    end
  end

  // ---------------- drivers ----------------
  bit rand_ready = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) mem_wr_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_timeout", in_ready, 1'b1);
  endtask

  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic rs);
    wait_idle();
    in_op    = op;
    in_func3 = f3;
    in_func7 = f7;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    restart  = rs;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
  endtask

  int imm_tab[21] = '{0, 5, -4, 2047, -2048, 2048, -2049, 4094, 4095, -4096, -4098, 31, 32, -1,
                      (1 << 20) - 2, 1 << 20, -(1 << 20), -(1 << 20) - 2, 32'h12345000,
                      32'hFFFFF000, 3};

  initial begin
    bit          e;
    logic [1:0]  c;
    logic [31:0] w;
    int          n_wr, n_err, stall_cnt;

    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; mem_wr_ready = 1'b1;
    in_op = '0; in_func3 = '0; in_func7 = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    // Model pinned against hand-encoded words.
    ref_encode(8, 0, 0, 1, 0, 0, 5, e, c, w);            check("ref_addi", w, 32'h00500093);
    ref_encode(4, 0, 0, 0, 1, 2, -4, e, c, w);           check("ref_beq", w, 32'hFE208EE3);
    ref_encode(2, 0, 0, 1, 0, 0, 2048, e, c, w);         check("ref_jal", w, 32'h001000EF);
    ref_encode(7, 0, 7'h20, 3, 1, 2, 0, e, c, w);        check("ref_sub", w, 32'h402081B3);
    ref_encode(8, 0, 0, 1, 0, 0, 4096, e, c, w);         check("ref_imm_err", {e, c}, 3'b110);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_wr_en", mem_wr_en, 1'b0);
    check("rst_wr_addr", mem_wr_addr, 32'd0);
    check("rst_wr_data", mem_wr_data, 32'd0);
    check("rst_err_valid", err_valid, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    send(8, 0, 0, 1, 0, 0, 5, 0);  wait_idle();
    check("addi_data", last_wr_data, 32'h00500093);
    check("addi_addr", last_wr_addr, 32'd0);
    send(4, 0, 0, 0, 1, 2, -4, 0); wait_idle();
    check("beq_data", last_wr_data, 32'hFE208EE3);
    check("beq_addr", last_wr_addr, 32'd4);
    send(2, 0, 0, 1, 0, 0, 2048, 0); wait_idle();
    check("jal_data", last_wr_data, 32'h001000EF);
    send(0, 0, 0, 5, 0, 0, 32'h12345000, 0); wait_idle();
    check("lui_data", last_wr_data, 32'h123452B7);
    check("lui_addr", last_wr_addr, 32'd12);

    n_wr = wr_seen; n_err = err_seen;
    send(8, 0, 0, 1, 0, 0, 4096, 0); wait_idle();
    check("imm_range_code", last_err_code, 2'b10);
    check("imm_range_err_cnt", err_seen, n_err + 1);
    check("imm_range_no_wr", wr_seen, n_wr);
    send(12, 0, 0, 1, 0, 0, 0, 0); wait_idle();
    check("bad_op_code", last_err_code, 2'b00);
    send(0, 0, 0, 5, 0, 0, 32'h12345000, 0); wait_idle();
    check("addr_after_err", last_wr_addr, 32'd16);

    send(7, 0, 7'h00, 3, 1, 2, 0, 1); wait_idle();
    check("restart_add_data", last_wr_data, 32'h002081B3);
    check("restart_add_addr", last_wr_addr, 32'd0);
    send(7, 0, 7'h20, 3, 1, 2, 0, 0); wait_idle();
    check("sub_data", last_wr_data, 32'h402081B3);
    check("sub_addr", last_wr_addr, 32'd4);

    // Memory back-pressure: ready low for 3 EMIT cycles.
    send(7, 3'b111, 7'h00, 4, 5, 6, 0, 0);
    mem_wr_ready = 1'b0;
    stall_cnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (mem_wr_en) stall_cnt++;
      check("stall_in_ready", in_ready, 1'b0);
    end
    mem_wr_ready = 1'b1;
    check("stall_en_cycles", stall_cnt, 4);
    wait_idle();
    check("stall_addr", last_wr_addr, 32'd8);

    // Reset in the middle of a write.
    send(5, 3'b010, 0, 7, 8, 0, -8, 0);
    mem_wr_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_wr_en", mem_wr_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", mem_wr_en, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_addr", mem_wr_addr, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_wr_ready = 1'b1;

    rand_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      logic [3:0]  op;
      logic [6:0]  f7;
      logic [31:0] imm;
      op  = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      imm = ($urandom_range(0, 4) == 0) ? $urandom : imm_tab[$urandom_range(0, 20)];
      send(op, 3'($urandom), f7, 5'($urandom), 5'($urandom), 5'($urandom), imm,
           $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 5) == 0) begin
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) begin
        wait_idle();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    mem_wr_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
